// File: rtl/alu_mc_pkg.sv
// alu_mc_pkg: shared definitions for the multi-cycle ALU.
//   - opcode encodings (5-bit)
//   - PSR flag bit positions
//   - FSM state type and the iterative-operation select type
package alu_mc_pkg;

  localparam int OP_BITS = 5;

  localparam logic [OP_BITS-1:0] OP_AND   = 5'b00000;
  localparam logic [OP_BITS-1:0] OP_OR    = 5'b00001;
  localparam logic [OP_BITS-1:0] OP_XOR   = 5'b00010;
  localparam logic [OP_BITS-1:0] OP_ADD   = 5'b00011;
  localparam logic [OP_BITS-1:0] OP_SUB   = 5'b00100;
  localparam logic [OP_BITS-1:0] OP_CMP   = 5'b00101;
  localparam logic [OP_BITS-1:0] OP_MOV   = 5'b00110;
  localparam logic [OP_BITS-1:0] OP_LSH   = 5'b00111;
  localparam logic [OP_BITS-1:0] OP_LUI   = 5'b01000;
  localparam logic [OP_BITS-1:0] OP_JCOND = 5'b01001;
  localparam logic [OP_BITS-1:0] OP_JAL   = 5'b01010;
  localparam logic [OP_BITS-1:0] OP_ADDU  = 5'b01011;
  localparam logic [OP_BITS-1:0] OP_MUL   = 5'b01100;
  localparam logic [OP_BITS-1:0] OP_MULH  = 5'b01101;
  localparam logic [OP_BITS-1:0] OP_DIVU  = 5'b01110;
  localparam logic [OP_BITS-1:0] OP_REMU  = 5'b01111;
  // Unassigned code used internally when the opcode has stray upper bits set.
  localparam logic [OP_BITS-1:0] OP_NONE  = 5'b11111;

  localparam int FLAG_C = 0;
  localparam int FLAG_L = 2;
  localparam int FLAG_F = 5;
  localparam int FLAG_Z = 6;
  localparam int FLAG_N = 7;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  typedef enum logic [1:0] {
    IT_MUL  = 2'b00,
    IT_MULH = 2'b01,
    IT_DIVU = 2'b10,
    IT_REMU = 2'b11
  } iter_sel_e;

  function automatic iter_sel_e iter_sel_of(input logic [OP_BITS-1:0] op);
    iter_sel_e sel;
    case (op)
      OP_MULH: sel = IT_MULH;
      OP_DIVU: sel = IT_DIVU;
      OP_REMU: sel = IT_REMU;
      default: sel = IT_MUL;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/alu_mc_if.sv
// alu_mc_if: request/response bundle between the controller and alu_mc.
//   master: drives start, alu_cont, a, b; observes busy, done, alu_out, psr_flags
//   slave : the ALU side of the same signals
interface alu_mc_if #(
  parameter int WIDTH         = 16,
  parameter int ALU_CONT_BITS = 5
);
  logic                     start;
  logic [ALU_CONT_BITS-1:0] alu_cont;
  logic [WIDTH-1:0]         a;
  logic [WIDTH-1:0]         b;
  logic                     busy;
  logic                     done;
  logic [WIDTH-1:0]         alu_out;
  logic [WIDTH-1:0]         psr_flags;

  modport master (
    output start, alu_cont, a, b,
    input  busy, done, alu_out, psr_flags
  );

  modport slave (
    input  start, alu_cont, a, b,
    output busy, done, alu_out, psr_flags
  );
endinterface

// File: rtl/alu_muldiv_iter.sv
// alu_muldiv_iter: shared WIDTH-step shift-add multiplier / restoring divider.
//   clk, reset   : clock, async active-low reset
//   load_i       : latch operands, clear accumulator, counter <= WIDTH
//   step_i       : perform one iteration, counter decrements
//   is_div_i     : sampled on load; 1 = divide, 0 = multiply
//   a_i, b_i     : operands (a = multiplicand/dividend, b = multiplier/divisor)
//   cnt_o        : remaining iteration count
//   next_o       : accumulator value after the current step (combinational);
//                  multiply -> {hi, lo} product, divide -> {remainder, quotient}
module alu_muldiv_iter #(
  parameter int WIDTH = 16
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        load_i,
  input  logic                        step_i,
  input  logic                        is_div_i,
  input  logic [WIDTH-1:0]            a_i,
  input  logic [WIDTH-1:0]            b_i,
  output logic [$clog2(WIDTH):0]      cnt_o,
  output logic [2*WIDTH-1:0]          next_o
);

  localparam int CW = $clog2(WIDTH) + 1;

  logic [2*WIDTH-1:0] acc_q;
  logic [WIDTH-1:0]   b_q;
  logic               div_q;
  logic [CW-1:0]      cnt_q;

  logic [WIDTH:0]     mul_sum_s;
  logic [WIDTH:0]     div_shift_s;
  logic               div_ge_s;
  logic [WIDTH:0]     div_rem_s;

  // One iteration of either algorithm; both work on the same 2*WIDTH accumulator.
  always_comb begin
    // Multiply: add b into the upper half when the current multiplier bit is set,
    // then shift the whole accumulator (including the carry) right by one.
    mul_sum_s   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} +
                  (acc_q[0] ? {1'b0, b_q} : {(WIDTH+1){1'b0}});
    // Divide: shift the next dividend bit into the partial remainder and
    // subtract the divisor if it fits; the comparison result is the quotient bit.
    div_shift_s = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    div_ge_s    = (div_shift_s >= {1'b0, b_q});
    if (div_ge_s) begin
      div_rem_s = div_shift_s - {1'b0, b_q};
    end else begin
      div_rem_s = div_shift_s;
    end
    if (div_q) begin
      next_o = {div_rem_s[WIDTH-1:0], acc_q[WIDTH-2:0], div_ge_s};
    end else begin
      next_o = {mul_sum_s, acc_q[WIDTH-1:1]};
    end
  end

  assign cnt_o = cnt_q;

  // Accumulator, operand and iteration-counter registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc_q <= {(2*WIDTH){1'b0}};
      b_q   <= {WIDTH{1'b0}};
      div_q <= 1'b0;
      cnt_q <= {CW{1'b0}};
    end else if (load_i) begin
      acc_q <= {{WIDTH{1'b0}}, a_i};
      b_q   <= b_i;
      div_q <= is_div_i;
      cnt_q <= CW'(WIDTH);
    end else if (step_i) begin
      acc_q <= next_o;
      cnt_q <= cnt_q - CW'(1);
    end else begin
      acc_q <= acc_q;
      cnt_q <= cnt_q;
    end
  end

endmodule

// File: rtl/alu_mc.sv
// alu_mc: multi-cycle ALU with start/done handshake and internal PSR register.
//   clk   : clock (rising edge)
//   reset : asynchronous active-low reset
//   bus   : alu_mc_if.slave
//           in : start, alu_cont, a, b
//           out: busy (iterative op running), done (1-cycle pulse),
//                alu_out (registered result), psr_flags {.., N, Z, F, 0, 0, L, 0, C}
module alu_mc
  import alu_mc_pkg::*;
#(
  parameter int WIDTH         = 16,
  parameter int ALU_CONT_BITS = 5
) (
  input  logic  clk,
  input  logic  reset,
  alu_mc_if.slave bus
);

  localparam int CW  = $clog2(WIDTH) + 1;
  localparam int SHW = $clog2(WIDTH) + 1;

  state_e           state_q, state_d;
  iter_sel_e        iter_sel_q, iter_sel_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] alu_out_q, out_d;
  logic [WIDTH-1:0] flags_q, flags_d;

  logic [OP_BITS-1:0] op_s;
  logic [OP_BITS-1:0] op_eff_s;
  logic [WIDTH:0]     add_s;
  logic [WIDTH:0]     sub_s;
  logic [SHW-1:0]     shamt_s;
  logic               b_zero_s;
  logic               is_iter_s;
  logic               is_div_s;
  logic [WIDTH-1:0]   sc_res_s;
  logic [WIDTH-1:0]   sc_flags_s;

  logic               load_s;
  logic               step_s;
  logic [CW-1:0]      cnt_s;
  logic [2*WIDTH-1:0] next_s;

  assign op_s = bus.alu_cont[OP_BITS-1:0];

  // Opcode decode; any code with stray upper bits falls into the "other" case.
  always_comb begin
    if (bus.alu_cont == ALU_CONT_BITS'(op_s)) begin
      op_eff_s = op_s;
    end else begin
      op_eff_s = OP_NONE;
    end
    is_div_s = (op_eff_s == OP_DIVU) || (op_eff_s == OP_REMU);
  end

  // Single-cycle results and their flag updates, plus iterative-op detection.
  always_comb begin
    add_s      = {1'b0, bus.a} + {1'b0, bus.b};
    sub_s      = {1'b0, bus.a} - {1'b0, bus.b};
    shamt_s    = bus.b[SHW-1:0];
    b_zero_s   = (bus.b == {WIDTH{1'b0}});
    sc_res_s   = {WIDTH{1'b0}};
    sc_flags_s = flags_q;
    is_iter_s  = 1'b0;
    case (op_eff_s)
      OP_AND:   sc_res_s = bus.a & bus.b;
      OP_OR:    sc_res_s = bus.a | bus.b;
      OP_XOR:   sc_res_s = bus.a ^ bus.b;
      OP_ADD: begin
        sc_res_s           = add_s[WIDTH-1:0];
        sc_flags_s[FLAG_C] = add_s[WIDTH];
        // Overflow: operands share a sign the result does not.
        sc_flags_s[FLAG_F] = (bus.a[WIDTH-1] == bus.b[WIDTH-1]) &&
                             (add_s[WIDTH-1] != bus.a[WIDTH-1]);
      end
      OP_ADDU:  sc_res_s = add_s[WIDTH-1:0];
      OP_SUB: begin
        sc_res_s           = sub_s[WIDTH-1:0];
        sc_flags_s[FLAG_C] = sub_s[WIDTH];
        sc_flags_s[FLAG_F] = (bus.a[WIDTH-1] != bus.b[WIDTH-1]) &&
                             (sub_s[WIDTH-1] != bus.a[WIDTH-1]);
      end
      OP_CMP: begin
        sc_res_s           = alu_out_q;
        sc_flags_s[FLAG_N] = ($signed(bus.a) < $signed(bus.b));
        sc_flags_s[FLAG_L] = sub_s[WIDTH];
        sc_flags_s[FLAG_Z] = (sub_s[WIDTH-1:0] == {WIDTH{1'b0}});
      end
      OP_MOV:   sc_res_s = bus.b;
      OP_LSH: begin
        if (bus.b[WIDTH-1]) begin
          sc_res_s = bus.a >> 1'b1;
        end else if (shamt_s >= SHW'(WIDTH)) begin
          sc_res_s = {WIDTH{1'b0}};
        end else begin
          sc_res_s = bus.a << shamt_s;
        end
      end
      OP_LUI:   sc_res_s = bus.b << 4'd8;
      OP_JCOND: sc_res_s = bus.a;
      OP_JAL:   sc_res_s = bus.a + {{(WIDTH-1){1'b0}}, 1'b1};
      OP_MUL, OP_MULH: is_iter_s = 1'b1;
      OP_DIVU: begin
        if (b_zero_s) begin
          sc_res_s           = {WIDTH{1'b1}};
          sc_flags_s[FLAG_F] = 1'b1;
        end else begin
          is_iter_s = 1'b1;
        end
      end
      OP_REMU: begin
        if (b_zero_s) begin
          sc_res_s           = bus.a;
          sc_flags_s[FLAG_F] = 1'b1;
        end else begin
          is_iter_s = 1'b1;
        end
      end
      default:  sc_res_s = {WIDTH{1'b0}};
    endcase
  end

  alu_muldiv_iter #(
    .WIDTH (WIDTH)
  ) u_iter (
    .clk      (clk),
    .reset    (reset),
    .load_i   (load_s),
    .step_i   (step_s),
    .is_div_i (is_div_s),
    .a_i      (bus.a),
    .b_i      (bus.b),
    .cnt_o    (cnt_s),
    .next_o   (next_s)
  );

  // FSM next-state and register-update logic.
  always_comb begin
    state_d    = state_q;
    iter_sel_d = iter_sel_q;
    done_d     = 1'b0;
    out_d      = alu_out_q;
    flags_d    = flags_q;
    load_s     = 1'b0;
    step_s     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          if (is_iter_s) begin
            load_s     = 1'b1;
            iter_sel_d = iter_sel_of(op_eff_s);
            state_d    = ST_RUN;
          end else begin
            done_d  = 1'b1;
            out_d   = sc_res_s;
            flags_d = sc_flags_s;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        step_s = 1'b1;
        // The final iteration and the result write share the same edge.
        if (cnt_s == CW'(1)) begin
          done_d          = 1'b1;
          state_d         = ST_IDLE;
          flags_d[FLAG_F] = 1'b0;
          if ((iter_sel_q == IT_MULH) || (iter_sel_q == IT_REMU)) begin
            out_d = next_s[2*WIDTH-1:WIDTH];
          end else begin
            out_d = next_s[WIDTH-1:0];
          end
        end else begin
          state_d = ST_RUN;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State, result, flag and done registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      iter_sel_q <= IT_MUL;
      done_q     <= 1'b0;
      alu_out_q  <= {WIDTH{1'b0}};
      flags_q    <= {WIDTH{1'b0}};
    end else begin
      state_q    <= state_d;
      iter_sel_q <= iter_sel_d;
      done_q     <= done_d;
      alu_out_q  <= out_d;
      flags_q    <= flags_d;
    end
  end

  assign bus.busy      = (state_q == ST_RUN);
  assign bus.done      = done_q;
  assign bus.alu_out   = alu_out_q;
  assign bus.psr_flags = flags_q;

endmodule
